// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
//   Bundles every fetch_queue signal except clock and reset.
//
//   Modports
//     slave  : fetch_queue side
//              in  : pc_i, flush, imem_rdata, dec_ready
//              out : imem_req, imem_addr, stall, dec_valid, dec_instr,
//                    dec_pc, count_o
//     master : environment side (program_counter / imem / decode),
//              with every direction reversed.
//
//   Parameters
//     WIDTH : PC width in bits
//     DEPTH : FIFO entries; sets the width of count_o
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] pc_i;
  logic             flush;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic [31:0]      imem_rdata;
  logic             stall;
  logic             dec_valid;
  logic             dec_ready;
  logic [31:0]      dec_instr;
  logic [WIDTH-1:0] dec_pc;
  logic [CW-1:0]    count_o;

  modport slave (
    input  pc_i, flush, imem_rdata, dec_ready,
    output imem_req, imem_addr, stall, dec_valid, dec_instr, dec_pc, count_o
  );

  modport master (
    output pc_i, flush, imem_rdata, dec_ready,
    input  imem_req, imem_addr, stall, dec_valid, dec_instr, dec_pc, count_o
  );
endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch buffer between program_counter and decode.
//   Each cycle the current PC is issued to a synchronous instruction memory
//   (1-cycle read latency); the returned instruction is captured together
//   with its PC into a DEPTH-entry FIFO and offered to decode through a
//   valid/ready handshake. stall holds program_counter so the FIFO can never
//   overflow, and flush discards the queue plus the in-flight fetch.
//
//   Ports
//     clk   : clock, rising edge
//     rst   : asynchronous, active-low reset
//     bus   : fetch_queue_if.slave
//               pc_i, flush, imem_rdata, dec_ready          (in)
//               imem_req, imem_addr, stall, dec_valid,
//               dec_instr, dec_pc, count_o                   (out)
//
//   Parameters
//     WIDTH : PC width in bits
//     DEPTH : FIFO entries, power of two, minimum 2
//     NOP   : instruction shown on dec_instr when nothing is valid
//
//   Build options
//     FETCHQ_BYPASS_EN : when defined, a response arriving at an empty FIFO
//                        is presented to decode in the same cycle (1-cycle
//                        fetch-to-decode latency); if decode takes it, it is
//                        never written. Undefined: fixed 2-cycle latency.
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int          WIDTH = 32,
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic           clk,
  input  logic           rst,
  fetch_queue_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 32;

  // FIFO storage: {pc, instr}
  logic [EW-1:0]    mem [DEPTH];

  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             req_q;
  logic [WIDTH-1:0] pc_q;

  logic [CW:0]      occ;
  logic             stall_w;
  logic             req_w;
  logic             push;
  logic             bypass;
  logic             fifo_valid;
  logic             pop;
  logic             wr_en;
  logic [EW-1:0]    head;

  always_comb begin
    // The in-flight request already owns a slot, so it counts against
    // capacity; this is what keeps a push from ever finding the FIFO full.
    occ        = {1'b0, count} + (CW+1)'(req_q);
    stall_w    = (occ >= (CW+1)'(DEPTH));
    // rst gating keeps the memory port quiet while reset is asserted.
    req_w      = rst && !stall_w && !bus.flush;
    // A response arriving in a flush cycle is wrong-path and is dropped.
    push       = req_q && !bus.flush;
    fifo_valid = (count != '0);
    head       = mem[rd_ptr];
`ifdef FETCHQ_BYPASS_EN
    bypass     = !fifo_valid && push;
`else
    bypass     = 1'b0;
`endif
    // Flush has priority: the head is not consumed in a flush cycle.
    pop        = fifo_valid && bus.dec_ready && !bus.flush;
    // A bypassed response taken by decode never occupies a slot.
    wr_en      = push && !(bypass && bus.dec_ready);
  end

  assign bus.stall     = stall_w;
  assign bus.imem_req  = req_w;
  assign bus.imem_addr = bus.pc_i;
  assign bus.count_o   = count;
  assign bus.dec_valid = fifo_valid || bypass;
  assign bus.dec_instr = bypass     ? bus.imem_rdata :
                         fifo_valid ? head[31:0]     : NOP;
  assign bus.dec_pc    = bypass     ? pc_q              :
                         fifo_valid ? head[EW-1:32]     : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      req_q  <= 1'b0;
      pc_q   <= '0;
    end else if (bus.flush) begin
      // imem_req is low in a flush cycle, so pc_q holds naturally.
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      req_q  <= 1'b0;
    end else begin
      req_q <= req_w;
      if (req_w)
        pc_q <= bus.pc_i;
      // DEPTH is a power of two, so pointer wrap is plain overflow.
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {pc_q, bus.imem_rdata};
  end

  // Capacity accounting must make a write into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(wr_en && !pop && count == CW'(DEPTH)));

endmodule
